imem_fetch_unit: RTL and testbench

- Instruction-fetch initiator for the banked synchronous instruction memory. It drives that memory's read port (select, address) and receives 48-bit instructions one cycle later.
- Delivers instructions with their PCs to the decode stage over a valid/ready handshake.
- Holds a 2-entry output queue so the pipeline sustains one instruction per cycle under backpressure.
- Accepts branch/jump redirects from the execute stage.

---
 rtl/imem_fetch_unit.sv | 137 +++++++++++++
 tb/tb_imem_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_unit
// Brief    : Instruction-fetch initiator for the banked synchronous
//            instruction memory. Issues one read per cycle, captures the
//            returned 48-bit instructions into a 2-entry queue and hands
//            them with their PCs to decode over valid/ready. Execute-stage
//            redirects flush the queue and any in-flight read.
// Options  : IMEM_FETCH_PERF_EN - adds o_bubble_count, a saturating count
//            of cycles where decode was ready but no instruction was valid.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 48,
    parameter int                       INST_BYTES    = 6,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_redirect,
    input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc,
    output logic                     o_mem_me,
    output logic [ADDRESS_WIDTH-1:0] o_mem_adr,
    input  logic [DATA_WIDTH-1:0]    i_mem_q,
    output logic                     o_inst_valid,
    input  logic                     i_inst_ready,
    output logic [DATA_WIDTH-1:0]    o_inst,
    output logic [ADDRESS_WIDTH-1:0] o_inst_pc
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]              o_bubble_count
`endif
);

    localparam logic [ADDRESS_WIDTH-1:0] C_PC_STEP = ADDRESS_WIDTH'(INST_BYTES);

    // Registered state and next-state values
    logic [ADDRESS_WIDTH-1:0]            fetch_pc_q,  fetch_pc_d;
    logic                                infl_q,      infl_d;
    logic [ADDRESS_WIDTH-1:0]            infl_pc_q,   infl_pc_d;
    logic [1:0][DATA_WIDTH-1:0]          qinst_q,     qinst_d;
    logic [1:0][ADDRESS_WIDTH-1:0]       qpc_q,       qpc_d;
    logic [1:0]                          cnt_q,       cnt_d;
    logic [ADDRESS_WIDTH-1:0]            mem_adr_q;

    logic                                pop;
    logic                                issue;
    logic [2:0]                          occ_after_pop;
    logic [1:0]                          base;

    // Entry 0 is always the queue head
    assign o_inst_valid = (cnt_q != 2'd0);
    assign o_inst       = qinst_q[0];
    assign o_inst_pc    = qpc_q[0];
    assign pop          = o_inst_valid && i_inst_ready;

    // Slots that will be occupied after this cycle's pop; a new read may be
    // issued only if it is guaranteed a queue slot when its data returns.
    assign occ_after_pop = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue         = !i_rst && !i_redirect && (occ_after_pop < 3'd2);

    // The address port holds its last issued value when idle
    assign o_mem_me  = issue;
    assign o_mem_adr = issue ? fetch_pc_q : mem_adr_q;

    // Next-state for fetch PC, in-flight tracking and the output queue
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        infl_d     = issue;
        infl_pc_d  = infl_pc_q;
        qinst_d    = qinst_q;
        qpc_d      = qpc_q;
        cnt_d      = cnt_q;
        base       = cnt_q - {1'b0, pop};

        if (i_redirect) begin
            // Flush: queued entries and the in-flight read are discarded
            fetch_pc_d = i_redirect_pc;
            cnt_d      = 2'd0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + C_PC_STEP;
                infl_pc_d  = fetch_pc_q;
            end
            if (pop) begin
                qinst_d[0] = qinst_q[1];
                qpc_d[0]   = qpc_q[1];
            end
            // Returned data lands behind whatever survives the pop; the
            // issue rule keeps that slot index at 0 or 1.
            if (infl_q) begin
                qinst_d[base[0]] = i_mem_q;
                qpc_d[base[0]]   = infl_pc_q;
            end
            cnt_d = base + {1'b0, infl_q};
        end
    end

    // State registers with asynchronous reset (reset overrides redirect)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
            qinst_q    <= '0;
            qpc_q      <= '0;
            cnt_q      <= 2'd0;
            mem_adr_q  <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_q     <= infl_d;
            infl_pc_q  <= infl_pc_d;
            qinst_q    <= qinst_d;
            qpc_q      <= qpc_d;
            cnt_q      <= cnt_d;
            mem_adr_q  <= o_mem_adr;
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] bubble_q;

    assign o_bubble_count = bubble_q;

    // Saturating count of decode-starved cycles; survives redirects
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bubble_q <= 32'd0;
        end else if (i_inst_ready && !o_inst_valid && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_unit
// Brief    : Self-checking bench for imem_fetch_unit: directed vector table,
//            hand-written redirect/wrap/reset sequences and randomized
//            traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc_s = '0;
    logic        me;
    logic [31:0] adr;
    logic [47:0] mem_q = '0;
    logic        valid;
    logic        ready = 1'b1;
    logic [47:0] inst;
    logic [31:0] inst_pc;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] bubbles;
`endif

    always #5 clk = ~clk;

    imem_fetch_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_redirect    (redir),
        .i_redirect_pc (rpc_s),
        .o_mem_me      (me),
        .o_mem_adr     (adr),
        .i_mem_q       (mem_q),
        .o_inst_valid  (valid),
        .i_inst_ready  (ready),
        .o_inst        (inst),
        .o_inst_pc     (inst_pc)
`ifdef IMEM_FETCH_PERF_EN
        ,
        .o_bubble_count(bubbles)
`endif
    );

    function automatic logic [47:0] tag(input logic [31:0] p);
        return {~p[15:0], p};
    endfunction

    // Memory: tagged data one cycle after a select, garbage otherwise
    always @(posedge clk) begin
        if (me) mem_q <= tag(adr);
        else    mem_q <= {16'($urandom), $urandom};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq_pc[$];
    int          mq_cyc[$];
    int          cyc;
    logic [31:0] m_adr, m_last_adr, m_bub;
    logic [31:0] got[$];

    task automatic model_reset();
        mq_pc.delete();
        mq_cyc.delete();
        cyc = 0;
        m_adr = 32'h0;
        m_last_adr = 32'h0;
        m_bub = 32'h0;
    endtask

    // Starts and ends at a falling edge; one clock cycle per call
    task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
        logic mvalid, mpop, mme;
        ready = rdy; redir = rd; rpc_s = rpc;
        #1;
        mvalid = (mq_pc.size() > 0) && (mq_cyc[0] <= cyc - 2);
        chk("valid", {63'd0, valid}, {63'd0, mvalid});
        if (mvalid) begin
            chk("inst_pc", {32'd0, inst_pc}, {32'd0, mq_pc[0]});
            chk("inst", {16'd0, inst}, {16'd0, tag(mq_pc[0])});
        end
        mpop = mvalid && rdy;
        mme  = !rd && ((mq_pc.size() - (mpop ? 1 : 0)) < 2);
        chk("mem_me", {63'd0, me}, {63'd0, mme});
        chk("mem_adr", {32'd0, adr}, {32'd0, mme ? m_adr : m_last_adr});
`ifdef IMEM_FETCH_PERF_EN
        chk("bubbles", {32'd0, bubbles}, {32'd0, m_bub});
`endif
        @(posedge clk);
        if (mpop) begin
            got.push_back(mq_pc[0]);
            void'(mq_pc.pop_front());
            void'(mq_cyc.pop_front());
        end
        if (rd) begin
            mq_pc.delete();
            mq_cyc.delete();
            m_adr = rpc;
        end else if (mme) begin
            mq_pc.push_back(m_adr);
            mq_cyc.push_back(cyc);
            m_last_adr = m_adr;
            m_adr = m_adr + 32'd6;
        end
        if (rdy && !mvalid && (m_bub != 32'hFFFF_FFFF)) m_bub = m_bub + 32'd1;
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges, released at a falling edge
    task automatic do_reset();
        ready = 1'b1; redir = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_me", {63'd0, me}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst_adr", {32'd0, adr}, 64'd0);
`ifdef IMEM_FETCH_PERF_EN
        chk("rst_bubbles", {32'd0, bubbles}, 64'd0);
`endif
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        e_me;
        logic [31:0] e_adr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic e_me, input logic [31:0] e_adr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.e_me = e_me;
        v.e_adr = e_adr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    initial begin
        // Startup: valid two cycles after the first issue, PCs 0,6,12,...
        tbl[0]  = mk(1, 0, 0,      1, 32'd0,   0, 0);
        tbl[1]  = mk(1, 0, 0,      1, 32'd6,   0, 0);
        tbl[2]  = mk(1, 0, 0,      1, 32'd12,  1, 32'd0);
        tbl[3]  = mk(1, 0, 0,      1, 32'd18,  1, 32'd6);
        tbl[4]  = mk(1, 0, 0,      1, 32'd24,  1, 32'd12);
        // Six stall cycles: head held, fetch throttled, address held
        for (int i = 5; i <= 10; i++) tbl[i] = mk(0, 0, 0, 0, 32'd24, 1, 32'd18);
        tbl[11] = mk(1, 0, 0,      1, 32'd30,  1, 32'd18);
        tbl[12] = mk(1, 0, 0,      1, 32'd36,  1, 32'd24);
        // Redirect with a queued entry and a read in flight
        tbl[13] = mk(0, 1, 32'h100, 0, 32'd36, 1, 32'd30);
        tbl[14] = mk(1, 0, 0,      1, 32'h100, 0, 0);
        tbl[15] = mk(1, 0, 0,      1, 32'h106, 0, 0);
        tbl[16] = mk(1, 0, 0,      1, 32'h10C, 1, 32'h100);
        tbl[17] = mk(1, 0, 0,      1, 32'h112, 1, 32'h106);

        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("reset_valid", {63'd0, valid}, 64'd0);
        chk("reset_me", {63'd0, me}, 64'd0);
        chk("reset_adr", {32'd0, adr}, 64'd0);
        chk("reset_inst", {16'd0, inst}, 64'd0);
        chk("reset_pc", {32'd0, inst_pc}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            ready = tbl[i].rdy; redir = tbl[i].rd; rpc_s = tbl[i].rpc;
            #1;
            chk($sformatf("tbl%0d_me", i), {63'd0, me}, {63'd0, tbl[i].e_me});
            chk($sformatf("tbl%0d_adr", i), {32'd0, adr}, {32'd0, tbl[i].e_adr});
            chk($sformatf("tbl%0d_valid", i), {63'd0, valid}, {63'd0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), {32'd0, inst_pc}, {32'd0, tbl[i].e_pc});
                chk($sformatf("tbl%0d_inst", i), {16'd0, inst}, {16'd0, tag(tbl[i].e_pc)});
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Model-checked phase
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // Redirect together with a pop, then a second redirect next cycle
        step(1, 1, 32'h200);
        got.delete();
        step(1, 1, 32'h300);
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        chk("t4_delivered", {63'd0, got.size() >= 2}, 64'd1);
        if (got.size() >= 2) begin
            chk("t4_first", {32'd0, got[0]}, 64'h300);
            chk("t4_second", {32'd0, got[1]}, 64'h306);
        end

        // Address wrap
        step(1, 1, 32'hFFFF_FFFC);
        got.delete();
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk("t5_delivered", {63'd0, got.size() >= 2}, 64'd1);
        if (got.size() >= 2) begin
            chk("t5_first", {32'd0, got[0]}, 64'hFFFF_FFFC);
            chk("t5_second", {32'd0, got[1]}, 64'h0000_0002);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        r_rdy, r_rd;
            logic [31:0] r_pc;
            r_rdy = ($urandom % 4) != 0;
            r_rd  = ($urandom % 20) == 0;
            r_pc  = ($urandom % 2) ? $urandom : (32'hFFFF_FFF0 + ($urandom % 16));
            step(r_rdy, r_rd, r_pc);
        end

        // Async reset mid-stream, then restart from the reset PC
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        for (int i = 0; i < 40; i++) step(($urandom % 3) != 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
